icon_update_ctrl: RTL and testbench

- Frame-synchronous update controller for the RojoBot icon renderer.
- Accepts bot location and info updates from the PicoBlaze-side bus through a req/ack handshake and holds them in a shadow buffer.
- Commits the buffered update to the icon renderer's locX/locY/botInfo inputs only at the start of vertical blanking, so the icon never tears mid-frame.
- Also provides the icon ROM orientation page, a frame counter, and an overrun counter for dropped (superseded) updates.

---
 rtl/icon_update_ctrl_if.sv | 12 +
 rtl/icon_update_ctrl.sv | 108 ++++++++++
 tb/tb_icon_update_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/icon_update_ctrl_if.sv
// Update request bus between the PicoBlaze-side requester and icon_update_ctrl.
// Requester holds upd_req with stable data until it sees the one-cycle upd_ack.
interface icon_update_ctrl_if;
  logic       upd_req;
  logic [7:0] upd_locX;
  logic [7:0] upd_locY;
  logic [7:0] upd_info;
  logic       upd_ack;

  modport master (output upd_req, upd_locX, upd_locY, upd_info, input upd_ack);
  modport slave  (input upd_req, upd_locX, upd_locY, upd_info, output upd_ack);
endinterface

// File: rtl/icon_update_ctrl.sv
// Frame-synchronous update controller for the RojoBot icon renderer: buffers
// location/info updates and commits them only at the start of vertical blanking.
module icon_update_ctrl #(
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned LOC_MAX  = 127,
  parameter logic [7:0]  INIT_X   = 8'd64,
  parameter logic [7:0]  INIT_Y   = 8'd64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [9:0]          vid_row,
  icon_update_ctrl_if.slave   updBus,
  output logic [7:0]          locX,
  output logic [7:0]          locY,
  output logic [7:0]          botInfo,
  output logic [2:0]          icon_page,
  output logic                pend,
  output logic [15:0]         frame_cnt,
  output logic [7:0]          overrun_cnt
);

  typedef enum logic {IDLE, PENDING} state_t;

  state_t     state, stateNext;
  logic       vbQ;
  logic       vblank;
  logic       vbRise;
  logic       accept;
  logic [7:0] reqX, reqY;
  logic [7:0] shadowX, shadowY, shadowInfo;

  function automatic logic [7:0] clampLoc(input logic [7:0] v);
    return (32'(v) > LOC_MAX) ? 8'(LOC_MAX) : v;
  endfunction

  assign vblank = (32'(vid_row) >= V_ACTIVE);
  assign vbRise = vblank & ~vbQ;
  assign accept = updBus.upd_req & ~updBus.upd_ack;
  assign reqX   = clampLoc(updBus.upd_locX);
  assign reqY   = clampLoc(updBus.upd_locY);
  assign pend   = (state == PENDING);

  always_comb begin
    stateNext = state;
    if (vbRise)
      stateNext = IDLE;
    else if (accept)
      stateNext = PENDING;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      vbQ            <= 1'b1;
      updBus.upd_ack <= 1'b0;
    end else begin
      state          <= stateNext;
      vbQ            <= vblank;
      updBus.upd_ack <= accept;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadowX    <= '0;
      shadowY    <= '0;
      shadowInfo <= '0;
    end else if (accept) begin
      shadowX    <= reqX;
      shadowY    <= reqY;
      shadowInfo <= updBus.upd_info;
    end
  end

  // A request landing on the vblank edge goes straight to the outputs,
  // superseding any stale shadow contents without counting an overrun.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      locX      <= INIT_X;
      locY      <= INIT_Y;
      botInfo   <= '0;
      icon_page <= '0;
    end else if (vbRise && accept) begin
      locX      <= reqX;
      locY      <= reqY;
      botInfo   <= updBus.upd_info;
      icon_page <= updBus.upd_info[2:0];
    end else if (vbRise && pend) begin
      locX      <= shadowX;
      locY      <= shadowY;
      botInfo   <= shadowInfo;
      icon_page <= shadowInfo[2:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt   <= '0;
      overrun_cnt <= '0;
    end else begin
      if (vbRise)
        frame_cnt <= frame_cnt + 16'd1;
      if (accept && pend && !vbRise && overrun_cnt != '1)
        overrun_cnt <= overrun_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_icon_update_ctrl.sv
// Directed bench for icon_update_ctrl; expected commits are queued at request
// time and popped at each vblank edge.
module tb_icon_update_ctrl;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  vid_row;
  logic [7:0]  locX, locY, botInfo;
  logic [2:0]  icon_page;
  logic        pend;
  logic [15:0] frame_cnt;
  logic [7:0]  overrun_cnt;

  icon_update_ctrl_if bus ();

  icon_update_ctrl #(.V_ACTIVE(480), .LOC_MAX(127), .INIT_X(8'd64), .INIT_Y(8'd64)) dut (
    .clk(clk), .reset_n(reset_n), .vid_row(vid_row), .updBus(bus.slave),
    .locX(locX), .locY(locY), .botInfo(botInfo), .icon_page(icon_page),
    .pend(pend), .frame_cnt(frame_cnt), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [23:0] q[$];
  logic [23:0] expCommit;
  logic [15:0] expFrames;
  logic [7:0]  expOver;

  function automatic logic [7:0] clampLoc(input logic [7:0] v);
    return (v > 8'd127) ? 8'd127 : v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReq(input logic [7:0] x, input logic [7:0] y, input logic [7:0] info);
    bus.upd_req  = 1'b1;
    bus.upd_locX = x;
    bus.upd_locY = y;
    bus.upd_info = info;
    tick();
    if (q.size() != 0) begin
      void'(q.pop_back());
      if (expOver != 8'd255) expOver++;
    end
    q.push_back({clampLoc(x), clampLoc(y), info});
    check("ack_pulse", 32'(bus.upd_ack), 32'd1);
    check("pend_set", 32'(pend), 32'd1);
    check("overrun", 32'(overrun_cnt), 32'(expOver));
    bus.upd_req = 1'b0;
    tick();
    check("ack_drop", 32'(bus.upd_ack), 32'd0);
  endtask

  task automatic checkOutputs(input string tag);
    check({tag, "_locX"}, 32'(locX), 32'(expCommit[23:16]));
    check({tag, "_locY"}, 32'(locY), 32'(expCommit[15:8]));
    check({tag, "_info"}, 32'(botInfo), 32'(expCommit[7:0]));
    check({tag, "_page"}, 32'(icon_page), 32'(expCommit[2:0]));
    check({tag, "_frames"}, 32'(frame_cnt), 32'(expFrames));
  endtask

  task automatic vblankCommit(input string tag);
    vid_row = 10'd480;
    tick();
    expFrames++;
    if (q.size() != 0) expCommit = q.pop_front();
    checkOutputs(tag);
    check({tag, "_pend"}, 32'(pend), 32'd0);
    vid_row = 10'd100;
    tick();
  endtask

  initial begin
    reset_n      = 1'b0;
    vid_row      = 10'd500;
    bus.upd_req  = 1'b0;
    bus.upd_locX = '0;
    bus.upd_locY = '0;
    bus.upd_info = '0;
    expCommit    = {8'd64, 8'd64, 8'd0};
    expFrames    = '0;
    expOver      = '0;

    // 1: reset values, no false vblank edge on release
    repeat (3) tick();
    checkOutputs("reset");
    check("reset_pend", 32'(pend), 32'd0);
    check("reset_ack", 32'(bus.upd_ack), 32'd0);
    check("reset_over", 32'(overrun_cnt), 32'd0);
    reset_n = 1'b1;
    repeat (3) tick();
    check("no_false_edge", 32'(frame_cnt), 32'd0);

    // 2: basic update held until vblank
    vid_row = 10'd100;
    tick();
    doReq(8'd10, 8'd20, 8'h03);
    check("hold_locX", 32'(locX), 32'd64);
    repeat (4) tick();
    check("hold_pend", 32'(pend), 32'd1);
    vblankCommit("basic");

    // vblank with nothing pending leaves outputs alone
    vblankCommit("idle_vb");

    // 4: clamping
    doReq(8'd200, 8'd128, 8'h05);
    vblankCommit("clamp");

    // 5: stale pending update, then request accepted on the vblank edge
    doReq(8'd50, 8'd50, 8'h01);
    vid_row = 10'd479;
    tick();
    bus.upd_req  = 1'b1;
    bus.upd_locX = 8'd30;
    bus.upd_locY = 8'd40;
    bus.upd_info = 8'h02;
    vid_row      = 10'd480;
    tick();
    q.delete();
    expCommit = {8'd30, 8'd40, 8'h02};
    expFrames++;
    checkOutputs("bypass");
    check("bypass_pend", 32'(pend), 32'd0);
    check("bypass_ack", 32'(bus.upd_ack), 32'd1);
    check("bypass_over", 32'(overrun_cnt), 32'd0);
    bus.upd_req = 1'b0;
    tick();
    check("bypass_ack_drop", 32'(bus.upd_ack), 32'd0);
    vid_row = 10'd100;
    tick();

    // 3: latest wins, then overrun saturation
    doReq(8'd5, 8'd5, 8'h00);
    doReq(8'd7, 8'd9, 8'h06);
    check("overrun_one", 32'(overrun_cnt), 32'd1);
    vblankCommit("latest");
    for (int i = 0; i < 300; i++)
      doReq(8'(i), 8'(i + 3), 8'(i));
    check("overrun_sat", 32'(overrun_cnt), 32'd255);
    vblankCommit("after_sat");

    // 6: reset mid-frame drops the pending update
    doReq(8'd11, 8'd12, 8'h04);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    q.delete();
    expCommit = {8'd64, 8'd64, 8'd0};
    expFrames = '0;
    expOver   = '0;
    checkOutputs("midreset");
    check("midreset_pend", 32'(pend), 32'd0);
    check("midreset_over", 32'(overrun_cnt), 32'd0);
    tick();
    vblankCommit("post_reset_vb");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
